// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : Issue/result bundle between the control unit and alu_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op_alu;
  logic             s_inm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             ovf;
  logic             busy;
  logic             done;

  // Control unit side: issues operations and consumes results.
  modport master (
    output start, op_alu, s_inm, a, b,
    input  y, zero, carry, neg, ovf, busy, done
  );

  // ALU side.
  modport slave (
    input  start, op_alu, s_inm, a, b,
    output y, zero, carry, neg, ovf, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with flags, shifts and iterative shift-add MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] c_OP_A    = 4'b0000;
  localparam logic [3:0] c_OP_NOT  = 4'b0001;
  localparam logic [3:0] c_OP_ADD  = 4'b0010;
  localparam logic [3:0] c_OP_SUB  = 4'b0011;
  localparam logic [3:0] c_OP_AND  = 4'b0100;
  localparam logic [3:0] c_OP_OR   = 4'b0101;
  localparam logic [3:0] c_OP_NEGA = 4'b0110;
  localparam logic [3:0] c_OP_NEGB = 4'b0111;
  localparam logic [3:0] c_OP_SHL  = 4'b1000;
  localparam logic [3:0] c_OP_SHR  = 4'b1001;
  localparam logic [3:0] c_OP_SAR  = 4'b1010;
  localparam logic [3:0] c_OP_MUL  = 4'b1011;
  localparam logic [3:0] c_OP_XOR  = 4'b1100;

  localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_y;
  logic               r_zero;
  logic               r_carry;
  logic               r_neg;
  logic               r_ovf;
  logic               r_done;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW-1:0]     r_cnt;

  logic               w_load_mul;
  logic               w_mul_last;
  logic               w_update;

  logic [WIDTH-1:0]   w_min;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [SHW-1:0]     w_sh;
  logic               w_sh_big;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sar;

  logic [WIDTH-1:0]   w_res_y;
  logic               w_res_c;
  logic               w_res_v;

  logic [WIDTH:0]     w_acc;
  logic [2*WIDTH-1:0] w_prod_nxt;

  logic [WIDTH-1:0]   w_fin_y;
  logic               w_fin_c;
  logic               w_fin_v;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_mul  = 1'b0;
    w_mul_last  = 1'b0;
    w_update    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op_alu == c_OP_MUL) begin
            w_load_mul  = 1'b1;
            w_state_nxt = S_MUL;
          end else begin
            w_update = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_mul_last  = 1'b1;
          w_update    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------ single-cycle datapath
  // Every subtract-style op is minuend - subtrahend; negation uses 0 - x.
  always_comb begin
    w_min = bus.a;
    w_sub = bus.b;
    case (bus.op_alu)
      c_OP_SUB: begin
        w_min = bus.s_inm ? bus.b : bus.a;
        w_sub = bus.s_inm ? bus.a : bus.b;
      end
      c_OP_NEGA: begin
        w_min = '0;
        w_sub = bus.a;
      end
      c_OP_NEGB: begin
        w_min = '0;
        w_sub = bus.b;
      end
      default: ;
    endcase
  end

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, w_min} - {1'b0, w_sub};

  // A set bit above the shift field means the amount is at least WIDTH.
  assign w_sh     = bus.b[SHW-1:0];
  assign w_sh_big = |bus.b[WIDTH-1:SHW];
  assign w_shl    = {1'b0, bus.a} << w_sh;
  assign w_shr    = {bus.a, 1'b0} >> w_sh;
  assign w_sar    = $signed({bus.a, 1'b0}) >>> w_sh;

  always_comb begin
    w_res_y = '0;
    w_res_c = 1'b0;
    w_res_v = 1'b0;
    case (bus.op_alu)
      c_OP_A:   w_res_y = bus.a;
      c_OP_NOT: w_res_y = ~bus.a;
      c_OP_ADD: begin
        w_res_y = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      c_OP_SUB, c_OP_NEGA, c_OP_NEGB: begin
        w_res_y = w_diff[WIDTH-1:0];
        w_res_c = w_diff[WIDTH];
        w_res_v = (w_min[MSB] != w_sub[MSB]) && (w_diff[MSB] != w_min[MSB]);
      end
      c_OP_AND: w_res_y = bus.a & bus.b;
      c_OP_OR:  w_res_y = bus.a | bus.b;
      c_OP_XOR: w_res_y = bus.a ^ bus.b;
      c_OP_SHL: begin
        if (!w_sh_big) begin
          w_res_y = w_shl[WIDTH-1:0];
          w_res_c = w_shl[WIDTH];
        end
      end
      c_OP_SHR: begin
        if (!w_sh_big) begin
          w_res_y = w_shr[WIDTH:1];
          w_res_c = w_shr[0];
        end
      end
      c_OP_SAR: begin
        if (w_sh_big) begin
          w_res_y = {WIDTH{bus.a[MSB]}};
        end else begin
          w_res_y = w_sar[WIDTH:1];
          w_res_c = w_sar[0];
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------- shift-add multiplier
  // r_prod holds {partial sum, remaining multiplier bits}; one bit retires per cycle.
  assign w_acc      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_acc, r_prod[WIDTH-1:1]};

  assign w_fin_y = w_mul_last ? w_prod_nxt[WIDTH-1:0]        : w_res_y;
  assign w_fin_c = w_mul_last ? |w_prod_nxt[2*WIDTH-1:WIDTH] : w_res_c;
  assign w_fin_v = w_mul_last ? 1'b0                         : w_res_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y     <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= w_update;
      if (w_update) begin
        r_y     <= w_fin_y;
        r_zero  <= (w_fin_y == '0);
        r_carry <= w_fin_c;
        r_neg   <= w_fin_y[MSB];
        r_ovf   <= w_fin_v;
      end
      if (w_load_mul) begin
        r_mcand <= bus.a;
        r_prod  <= {{WIDTH{1'b0}}, bus.b};
        r_cnt   <= c_CNT_LAST;
      end else if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.y     = r_y;
  assign bus.zero  = r_zero;
  assign bus.carry = r_carry;
  assign bus.neg   = r_neg;
  assign bus.ovf   = r_ovf;
  assign bus.done  = r_done;
  assign bus.busy  = (r_state == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic         c;
    logic         n;
    logic         v;
  } res_t;

  typedef struct {
    logic [3:0]   op;
    logic         sinm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic res_t model(input logic [3:0] op, input logic sinm,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    res_t         r;
    logic [W-1:0] m;
    logic [W-1:0] s;
    logic [31:0]  p;
    int           sd;
    int           k;
    r  = '0;
    k  = int'(b);
    case (op)
      4'd0: r.y = a;
      4'd1: r.y = ~a;
      4'd2: begin
        p   = 32'(a) + 32'(b);
        r.y = p[15:0];
        r.c = p[16];
        sd  = int'($signed(a)) + int'($signed(b));
        r.v = (sd > 32767) || (sd < -32768);
      end
      4'd3, 4'd6, 4'd7: begin
        if (op == 4'd3) begin
          m = sinm ? b : a;
          s = sinm ? a : b;
        end else begin
          m = '0;
          s = (op == 4'd6) ? a : b;
        end
        r.y = m - s;
        r.c = (s > m);
        sd  = int'($signed(m)) - int'($signed(s));
        r.v = (sd > 32767) || (sd < -32768);
      end
      4'd4:  r.y = a & b;
      4'd5:  r.y = a | b;
      4'd12: r.y = a ^ b;
      4'd8: begin
        if (k < W) begin
          p   = 32'(a) << k;
          r.y = p[15:0];
          r.c = p[16];
        end
      end
      4'd9: begin
        if (k < W) begin
          r.y = a >> k;
          r.c = (k != 0) ? a[k-1] : 1'b0;
        end
      end
      4'd10: begin
        if (k >= W) begin
          r.y = {W{a[W-1]}};
        end else begin
          r.y = 16'($signed(a) >>> k);
          r.c = (k != 0) ? a[k-1] : 1'b0;
        end
      end
      4'd11: begin
        p   = 32'(a) * 32'(b);
        r.y = p[15:0];
        r.c = (p[31:16] != 16'h0);
      end
      default: r.y = '0;
    endcase
    r.z = (r.y == '0);
    r.n = r.y[W-1];
    return r;
  endfunction

  // Presents one operation for exactly one sampling edge; returns #1 after it.
  task automatic drive(input logic [3:0] op, input logic sinm,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_alu = op;
    bus.s_inm  = sinm;
    bus.a      = a;
    bus.b      = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = $urandom();
    bus.b      = $urandom();
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok     = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.y, bus.zero, bus.carry, bus.neg, bus.ovf, bus.busy, bus.done} !==
        {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got y=%h z%b c%b n%b v%b busy%b done%b, want y=0000 z1 c0 n0 v0 busy0 done0",
               bus.y, bus.zero, bus.carry, bus.neg, bus.ovf, bus.busy, bus.done);
    end
  endtask

  task automatic test_single_ops();
    vec_t tbl[$];
    bit   ok;
    int   cyc;
    res_t got;
    res_t exp;
    tbl.push_back('{4'h2, 1'b0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}});
    tbl.push_back('{4'h2, 1'b0, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}});
    tbl.push_back('{4'h3, 1'b0, 16'h0003, 16'h0005, '{16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0}});
    tbl.push_back('{4'h3, 1'b1, 16'h0003, 16'h0005, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{4'hA, 1'b0, 16'h8000, 16'h0004, '{16'hF800, 1'b0, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{4'h8, 1'b0, 16'h8001, 16'h0001, '{16'h0002, 1'b0, 1'b1, 1'b0, 1'b0}});
    tbl.push_back('{4'h9, 1'b0, 16'h1234, 16'd20,   '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{4'h9, 1'b0, 16'h0003, 16'h0001, '{16'h0001, 1'b0, 1'b1, 1'b0, 1'b0}});
    tbl.push_back('{4'h8, 1'b0, 16'h8001, 16'h0000, '{16'h8001, 1'b0, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{4'hA, 1'b0, 16'h8000, 16'd16,   '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}});
    tbl.push_back('{4'h6, 1'b0, 16'h8000, 16'h1234, '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b1}});
    tbl.push_back('{4'h7, 1'b0, 16'h1234, 16'h0000, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{4'hC, 1'b0, 16'hF0F0, 16'hFF00, '{16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0}});
    tbl.push_back('{4'hE, 1'b0, 16'hFFFF, 16'hFFFF, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}});
    foreach (tbl[i]) begin
      sb.push_back(tbl[i].e);
      drive(tbl[i].op, tbl[i].sinm, tbl[i].a, tbl[i].b);
      wait_done(1, ok, cyc);
      exp = sb.pop_front();
      got = {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf};
      n_vec++;
      if (!ok || got !== exp) begin
        n_err++;
        $display("FAIL single_op[%0d] op=%h: done=%b got y=%h z%b c%b n%b v%b, want y=%h z%b c%b n%b v%b",
                 i, tbl[i].op, ok, got.y, got.z, got.c, got.n, got.v, exp.y, exp.z, exp.c, exp.n, exp.v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    bit   ok;
    int   cyc;
    int   busy_cnt;
    int   extra_done;
    res_t got;
    res_t exp;

    sb.push_back('{16'h1230, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(4'hB, 1'b0, 16'h0123, 16'h0010);
    busy_cnt = 0;
    cyc      = 0;
    while (cyc < 40 && bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (busy_cnt != 16 || cyc != 16 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mul_timing: busy cycles=%0d done after=%0d busy_at_done=%b, want 16 16 0",
               busy_cnt, cyc, bus.busy);
    end
    exp = sb.pop_front();
    got = {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mul_0123x10: got y=%h z%b c%b n%b v%b, want y=%h z%b c%b n%b v%b",
               got.y, got.z, got.c, got.n, got.v, exp.y, exp.z, exp.c, exp.n, exp.v);
    end
    @(posedge clk);
    #1;

    // A start pulsed mid-multiply must be dropped, not queued.
    sb.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
    drive(4'hB, 1'b0, 16'h1000, 16'h0010);
    @(posedge clk);
    #1;
    drive(4'h2, 1'b0, 16'h0001, 16'h0001);
    wait_done(40, ok, cyc);
    exp = sb.pop_front();
    got = {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf};
    n_vec++;
    if (!ok || cyc != 14 || got !== exp) begin
      n_err++;
      $display("FAIL mul_1000x10: done=%b after=%0d got y=%h z%b c%b n%b v%b, want done after 14 y=%h z%b c%b n%b v%b",
               ok, cyc, got.y, got.z, got.c, got.n, got.v, exp.y, exp.z, exp.c, exp.n, exp.v);
    end
    extra_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
    end
    n_vec++;
    if (extra_done != 0 || bus.y !== 16'h0000) begin
      n_err++;
      $display("FAIL mul_ignore_start: extra done/busy cycles=%0d y=%h, want 0 and y=0000",
               extra_done, bus.y);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops[4];
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    res_t         got;
    res_t         exp;
    ops = '{4'h2, 4'h3, 4'h5, 4'h0};
    av  = '{16'h1111, 16'h0010, 16'h0F00, 16'hBEEF};
    bv  = '{16'h2222, 16'h0020, 16'h00F0, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      bus.op_alu = ops[i];
      bus.s_inm  = 1'b0;
      bus.a      = av[i];
      bus.b      = bv[i];
      bus.start  = 1'b1;
      sb.push_back(model(ops[i], 1'b0, av[i], bv[i]));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf};
      n_vec++;
      if (bus.done !== 1'b1 || got !== exp) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: done=%b got y=%h z%b c%b n%b v%b, want done=1 y=%h z%b c%b n%b v%b",
                 i, bus.done, got.y, got.z, got.c, got.n, got.v, exp.y, exp.z, exp.c, exp.n, exp.v);
      end
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.done !== 1'b0 || bus.y !== 16'hBEEF) begin
      n_err++;
      $display("FAIL back_to_back_hold: done=%b y=%h, want done=0 y=beef", bus.done, bus.y);
    end
  endtask

  task automatic test_mul_abort();
    int dones;
    int busys;
    drive(4'hB, 1'b0, 16'h0003, 16'h0005);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    busys = 0;
    repeat (25) begin
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busys++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (dones != 0 || busys != 0 ||
        {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mul_abort: dones=%0d busy cycles=%0d y=%h z%b, want 0 0 y=0000 z1",
               dones, busys, bus.y, bus.zero);
    end
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sinm;
    bit           ok;
    int           cyc;
    res_t         got;
    res_t         exp;
    for (int i = 0; i < 60; i++) begin
      op   = 4'($urandom_range(0, 15));
      a    = 16'($urandom());
      b    = 16'($urandom());
      sinm = 1'($urandom_range(0, 1));
      if (op >= 4'h8 && op <= 4'hA) b = 16'($urandom_range(0, 20));
      sb.push_back(model(op, sinm, a, b));
      drive(op, sinm, a, b);
      wait_done(W + 4, ok, cyc);
      exp = sb.pop_front();
      got = {bus.y, bus.zero, bus.carry, bus.neg, bus.ovf};
      n_vec++;
      if (!ok || got !== exp) begin
        n_err++;
        $display("FAIL random[%0d] op=%h a=%h b=%h s=%b: done=%b got y=%h z%b c%b n%b v%b, want y=%h z%b c%b n%b v%b",
                 i, op, a, b, sinm, ok, got.y, got.z, got.c, got.n, got.v,
                 exp.y, exp.z, exp.c, exp.n, exp.v);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op_alu = 4'h0;
    bus.s_inm  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    test_reset();
    test_single_ops();
    test_mul();
    test_random();
    test_back_to_back();
    test_mul_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's 16-bit combinational ALU.
- Adds shifts, XOR, and an iterative multi-cycle multiply.
- Provides a full registered flag set (Z, C, N, V) and a start/busy/done handshake so the control unit can stall on multi-cycle ops.
- Sits between the register file read ports and the writeback mux; the control unit issues `start` and waits for `done`.

Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), derived; width of the shift-amount field (not overridable).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, issue pulse; operands and op sampled on the edge where start=1 and busy=0.
- op_alu, input, 4, operation select (encoding below).
- s_inm, input, 1, for SUB: 1 computes b−a, 0 computes a−b.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B; also the shift amount for shift ops.
- y, output, WIDTH, registered result.
- zero, output, 1, registered: y==0.
- carry, output, 1, registered carry/borrow/shift-out/mul-overflow.
- neg, output, 1, registered: y[WIDTH-1].
- ovf, output, 1, registered signed overflow.
- busy, output, 1, high while a multi-cycle op is in progress.
- done, output, 1, one-cycle pulse when y/flags update.

Behaviour:
- Reset: y=0, zero=1, carry=0, neg=0, ovf=0, busy=0, done=0, FSM→IDLE. Reset takes priority over every other event.
- Op encoding:
  - 0000 A
  - 0001 ~A
  - 0010 A+B
  - 0011 SUB
  - 0100 A&B
  - 0101 A|B
  - 0110 −A
  - 0111 −B
  - 1000 SHL A by B
  - 1001 SHR (logical)
  - 1010 SAR
  - 1011 MUL (low WIDTH bits of A×B, unsigned)
  - 1100 A^B
  - 1101–1111 reserved: y=0, zero=1, other flags 0, single-cycle.
- FSM states: IDLE, MUL.
  - IDLE + start, op≠MUL: compute and register y/flags; done=1 in the next cycle; busy stays 0.
  - IDLE + start, op=MUL: latch a and b, clear the accumulator, go to MUL.
  - MUL: busy=1 for exactly WIDTH cycles, using shift-add, one multiplier bit per cycle. After the last iteration, y/flags register, done=1 for one cycle, state returns to IDLE.
  - For start sampled in cycle k, MUL gives busy in cycles k+1..k+WIDTH and done in cycle k+WIDTH+1.
  - Single-cycle ops give done in cycle k+1.
- start while busy=1 is ignored; no queueing. start in the cycle done=1 (busy=0) is accepted, allowing back-to-back single-cycle ops with done every cycle.
- Operands may change after the sampling edge; internal copies are used.
- y and flags hold their value between done pulses.
- Flags on each update: zero=(y==0), neg=y[MSB].
- carry:
  - ADD: carry-out.
  - SUB, −A, −B: borrow, i.e. 1 when the unsigned subtrahend > minuend; −X is treated as 0−X.
  - Shifts: last bit shifted out; 0 if amount=0 or amount≥WIDTH.
  - MUL: 1 if the upper WIDTH bits of the full product are nonzero.
  - Logic ops and A: 0.
- ovf:
  - Two's-complement signed overflow for ADD, SUB, −A, −B; −MIN sets ovf=1.
  - 0 for all other ops.
- Shift amount is the full b value. If b≥WIDTH: SHL/SHR give 0, SAR gives all bits equal to a[MSB].
- Reset during MUL: aborts, no done, outputs take reset values.

Test Plan:
- Reset then idle (WIDTH=16) → y=0x0000, zero=1, busy=0, done=0.
- ADD a=0xFFFF, b=0x0001, start for 1 cycle → next cycle done=1, y=0x0000, zero=1, carry=1, ovf=0.
- ADD a=0x7FFF, b=0x0001 → y=0x8000, neg=1, ovf=1.
- SUB a=0x0003, b=0x0005:
  - s_inm=0 → y=0xFFFE, carry=1, neg=1.
  - s_inm=1 → y=0x0002, carry=0.
- Shifts:
  - SAR a=0x8000, b=4 → y=0xF800, carry=0.
  - SHL a=0x8001, b=1 → y=0x0002, carry=1.
  - SHR b=20 → y=0.
- MUL a=0x0123, b=0x0010:
  - busy high 16 cycles, done at cycle k+17, y=0x1230, carry=0.
  - a=0x1000, b=0x0010 → y=0, zero=1, carry=1.
  - A second start pulsed mid-MUL is ignored.
  - Reset asserted at cycle k+5 → no done, y=0, busy=0.
